// File: rtl/sr_pattern_pkg.sv
// Shared constants for the serial delay-line pattern generator.
package sr_pattern_pkg;

    localparam int unsigned LFSR_W    = 7;
    localparam int unsigned ERR_CNT_W = 8;

    // Pattern select encodings
    localparam logic [1:0] MODE_ZERO  = 2'b00;
    localparam logic [1:0] MODE_ONE   = 2'b01;
    localparam logic [1:0] MODE_ALT   = 2'b10;
    localparam logic [1:0] MODE_PRBS7 = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    // x^7 + x^6 + 1 feedback taps (bit indices of the shift register)
    localparam int unsigned PRBS7_TAP_HI = 6;
    localparam int unsigned PRBS7_TAP_LO = 5;

    localparam logic [LFSR_W-1:0] PRBS7_SEED_DEFAULT = 7'h01;

    // An all-zero seed would lock the LFSR; substitute the default.
    function automatic logic [LFSR_W-1:0] prbs7_fix_seed(input logic [LFSR_W-1:0] s);
        return (s == '0) ? PRBS7_SEED_DEFAULT : s;
    endfunction

endpackage

// File: rtl/sr_prbs7_lfsr.sv
// Fibonacci PRBS7 generator: load seeds the register, adv shifts one step.
module sr_prbs7_lfsr
    import sr_pattern_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [LFSR_W-1:0] seed,
    input  logic              adv,
    output logic              prbs_bit
);

    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-1:0] lfsr_d;

    // Next LFSR value: seed load takes priority over advance
    always_comb begin
        lfsr_d = lfsr_q;
        if (load) begin
            lfsr_d = prbs7_fix_seed(seed);
        end else if (adv) begin
            lfsr_d = {lfsr_q[LFSR_W-2:0], lfsr_q[PRBS7_TAP_HI] ^ lfsr_q[PRBS7_TAP_LO]};
        end
    end

    // LFSR state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= '0;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign prbs_bit = lfsr_q[LFSR_W-1];

endmodule

// File: rtl/sr_pattern_gen.sv
// Burst pattern source for the serial delay line: paced bit strobes with
// constant, alternating or PRBS7 data. Defining SR_PATGEN_ERRINJ_EN adds
// single-bit error injection (err_inject in, err_cnt out).
module sr_pattern_gen
    import sr_pattern_pkg::*;
#(
    parameter int unsigned LEN_W = 11,
    parameter int unsigned DIV_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [1:0]        mode,
    input  logic [LEN_W-1:0]  burst_len,
    input  logic [DIV_W-1:0]  rate_div,
    input  logic [LFSR_W-1:0] seed,
`ifdef SR_PATGEN_ERRINJ_EN
    input  logic                 err_inject,
    output logic [ERR_CNT_W-1:0] err_cnt,
`endif
    output logic              sr_din,
    output logic              sr_clken,
    output logic              busy,
    output logic              done
);

    state_e            state_q,   state_d;
    logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
    logic [LEN_W-1:0]  rem_q,     rem_d;
    logic [1:0]        mode_q,    mode_d;
    logic [DIV_W-1:0]  rate_q,    rate_d;
    logic              alt_q,     alt_d;
    logic              sr_din_q,  sr_din_d;
    logic              sr_clken_q, sr_clken_d;
    logic              busy_q,    busy_d;
    logic              done_q,    done_d;

    logic              start_acc_c;
    logic              strobe_c;
    logic              pat_bit_c;
    logic              prbs_bit;
    logic              inv_c;

`ifdef SR_PATGEN_ERRINJ_EN
    logic                 err_arm_q, err_arm_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
`endif

    assign start_acc_c = (state_q == ST_IDLE) && start && !abort;

    sr_prbs7_lfsr u_lfsr (
        .clk      (clk),
        .rst      (rst),
        .load     (start_acc_c),
        .seed     (seed),
        .adv      (strobe_c && (mode_q == MODE_PRBS7)),
        .prbs_bit (prbs_bit)
    );

    // Current pattern bit for the selected mode
    always_comb begin
        pat_bit_c = 1'b0;
        case (mode_q)
            MODE_ZERO:  pat_bit_c = 1'b0;
            MODE_ONE:   pat_bit_c = 1'b1;
            MODE_ALT:   pat_bit_c = alt_q;
            MODE_PRBS7: pat_bit_c = prbs_bit;
            default:    pat_bit_c = 1'b0;
        endcase
    end

`ifdef SR_PATGEN_ERRINJ_EN
    assign inv_c = err_arm_q;
`else
    assign inv_c = 1'b0;
`endif

    // FSM next state, pacing divider, bit counter and registered outputs
    always_comb begin
        state_d    = state_q;
        div_cnt_d  = div_cnt_q;
        rem_d      = rem_q;
        mode_d     = mode_q;
        rate_d     = rate_q;
        alt_d      = alt_q;
        sr_din_d   = sr_din_q;
        sr_clken_d = 1'b0;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        strobe_c   = 1'b0;
`ifdef SR_PATGEN_ERRINJ_EN
        err_arm_d  = err_arm_q;
        err_cnt_d  = err_cnt_q;
`endif

        case (state_q)
            ST_IDLE: begin
`ifdef SR_PATGEN_ERRINJ_EN
                err_arm_d = 1'b0;
`endif
                if (start_acc_c) begin
                    mode_d    = mode;
                    rate_d    = rate_div;
                    rem_d     = burst_len;
                    div_cnt_d = '0;
                    alt_d     = 1'b0;
                    state_d   = (burst_len == '0) ? ST_DONE : ST_RUN;
`ifdef SR_PATGEN_ERRINJ_EN
                    err_cnt_d = '0;
`endif
                end
            end
            ST_RUN: begin
                busy_d = 1'b1;
                if (div_cnt_q == '0) begin
                    strobe_c   = 1'b1;
                    sr_clken_d = 1'b1;
                    sr_din_d   = pat_bit_c ^ inv_c;
                    div_cnt_d  = rate_q;
                    rem_d      = rem_q - LEN_W'(1);
                    alt_d      = ~alt_q;
                    if (rem_q == LEN_W'(1)) begin
                        state_d = ST_DONE;
                    end
                end else begin
                    div_cnt_d = div_cnt_q - DIV_W'(1);
                end
`ifdef SR_PATGEN_ERRINJ_EN
                // Consume an armed error on this strobe, then re-arm on a new pulse
                if (strobe_c && err_arm_q) begin
                    err_arm_d = 1'b0;
                    if (err_cnt_q != '1) begin
                        err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
                    end
                end
                if (err_inject) begin
                    err_arm_d = 1'b1;
                end
`endif
            end
            ST_DONE: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort overrides everything, including a same-cycle start
        if (abort) begin
            state_d    = ST_IDLE;
            sr_clken_d = 1'b0;
            sr_din_d   = 1'b0;
            busy_d     = 1'b0;
            done_d     = 1'b0;
`ifdef SR_PATGEN_ERRINJ_EN
            err_arm_d  = 1'b0;
`endif
        end
    end

    // State, counters, config and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            div_cnt_q  <= '0;
            rem_q      <= '0;
            mode_q     <= MODE_ZERO;
            rate_q     <= '0;
            alt_q      <= 1'b0;
            sr_din_q   <= 1'b0;
            sr_clken_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_cnt_q  <= div_cnt_d;
            rem_q      <= rem_d;
            mode_q     <= mode_d;
            rate_q     <= rate_d;
            alt_q      <= alt_d;
            sr_din_q   <= sr_din_d;
            sr_clken_q <= sr_clken_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

`ifdef SR_PATGEN_ERRINJ_EN
    // Error injection flag and saturating counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_arm_q <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            err_arm_q <= err_arm_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`endif

    assign sr_din   = sr_din_q;
    assign sr_clken = sr_clken_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_sr_pattern_gen.sv
// Directed bench for sr_pattern_gen: table of bursts plus hand-written
// sequences for abort, restart-while-busy and asynchronous reset.
module tb_sr_pattern_gen;

    logic        clk;
    logic        rst;
    logic        start;
    logic        abort;
    logic [1:0]  mode;
    logic [10:0] burst_len;
    logic [7:0]  rate_div;
    logic [6:0]  seed;
    logic        sr_din;
    logic        sr_clken;
    logic        busy;
    logic        done;
`ifdef SR_PATGEN_ERRINJ_EN
    logic        err_inject;
    logic [7:0]  err_cnt;
`endif

    int checks;
    int failures;

    sr_pattern_gen #(.LEN_W(11), .DIV_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .mode      (mode),
        .burst_len (burst_len),
        .rate_div  (rate_div),
        .seed      (seed),
`ifdef SR_PATGEN_ERRINJ_EN
        .err_inject(err_inject),
        .err_cnt   (err_cnt),
`endif
        .sr_din    (sr_din),
        .sr_clken  (sr_clken),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  mode;
        logic [10:0] len;
        logic [7:0]  div;
        logic [6:0]  seed;
        int          exp_done_cyc;   // sample index (0 = cycle after start edge) of done
        int          exp_busy;       // number of cycles busy is high
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Reference PRBS7 step and expected bit for the i-th strobe
    function automatic logic [6:0] prbs_next(input logic [6:0] s);
        return {s[5:0], s[6] ^ s[5]};
    endfunction

    task automatic run_burst(input vec_t v, input int idx);
        logic [6:0] lfsr;
        logic       exp_bit;
        int         n;
        int         done_cyc;
        int         done_cnt;
        int         busy_cnt;
        int         budget;
        lfsr     = (v.seed == 7'h00) ? 7'h01 : v.seed;
        n        = 0;
        done_cyc = -1;
        done_cnt = 0;
        busy_cnt = 0;
        budget   = int'(v.len) * (int'(v.div) + 1) + 8;
        @(negedge clk);
        mode = v.mode; burst_len = v.len; rate_div = v.div; seed = v.seed; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (sr_clken) begin
                check($sformatf("v%0d_strobe%0d_cycle", idx, n), 32'(k), 32'(1 + n * (int'(v.div) + 1)));
                case (v.mode)
                    2'b00:   exp_bit = 1'b0;
                    2'b01:   exp_bit = 1'b1;
                    2'b10:   exp_bit = n[0];
                    default: begin exp_bit = lfsr[6]; lfsr = prbs_next(lfsr); end
                endcase
                check($sformatf("v%0d_bit%0d", idx, n), 32'(sr_din), 32'(exp_bit));
                n++;
            end
            if (busy) busy_cnt++;
            if (done) begin
                if (done_cnt == 0) done_cyc = k;
                done_cnt++;
            end
        end
        check($sformatf("v%0d_strobes", idx), 32'(n), 32'(v.len));
        check($sformatf("v%0d_done_cycle", idx), 32'(done_cyc), 32'(v.exp_done_cyc));
        check($sformatf("v%0d_done_count", idx), 32'(done_cnt), 32'd1);
        check($sformatf("v%0d_busy_cycles", idx), 32'(busy_cnt), 32'(v.exp_busy));
    endtask

    initial begin
        int n;
        int bad;
        int ones;
        int done_cyc;
        bit hit;
        checks   = 0;
        failures = 0;
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        mode = 2'b00; burst_len = '0; rate_div = '0; seed = '0;
`ifdef SR_PATGEN_ERRINJ_EN
        err_inject = 1'b0;
`endif

        //            mode   len      div   seed   done  busy
        vecs[0] = '{2'b01, 11'd5,   8'd0, 7'h00,   6,    5};
        vecs[1] = '{2'b10, 11'd4,   8'd2, 7'h00,  11,   10};
        vecs[2] = '{2'b11, 11'd254, 8'd0, 7'h00, 255,  254};
        vecs[3] = '{2'b00, 11'd0,   8'd5, 7'h00,   1,    0};
        vecs[4] = '{2'b00, 11'd3,   8'd1, 7'h00,   6,    5};
        vecs[5] = '{2'b11, 11'd10,  8'd3, 7'h5A,  38,   37};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_sr_din", 32'(sr_din), 32'd0);
        check("rst_sr_clken", 32'(sr_clken), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            run_burst(vecs[i], i);
        end

        // Long burst aborted after 300 bits
        @(negedge clk);
        mode = 2'b10; burst_len = 11'd1024; rate_div = 8'd0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        n = 0;
        hit = 1'b0;
        for (int k = 0; k < 1100 && !hit; k++) begin
            @(negedge clk);
            if (sr_clken) n++;
            if (n == 300) begin
                abort = 1'b1;
                hit = 1'b1;
            end
        end
        check("abort_reached_300", 32'(n), 32'd300);
        @(negedge clk);
        check("abort_clken_next", 32'(sr_clken), 32'd0);
        check("abort_busy_next", 32'(busy), 32'd0);
        check("abort_din_next", 32'(sr_din), 32'd0);
        abort = 1'b0;
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (done || sr_clken || busy) bad++;
        end
        check("abort_no_done", 32'(bad), 32'd0);
        run_burst('{2'b01, 11'd2, 8'd0, 7'h00, 3, 2}, 6);

        // Abort and start together in IDLE: abort wins
        @(negedge clk);
        mode = 2'b01; burst_len = 11'd4; start = 1'b1; abort = 1'b1;
        @(posedge clk);
        #1 start = 1'b0; abort = 1'b0;
        bad = 0;
        repeat (8) begin
            @(negedge clk);
            if (done || sr_clken || busy) bad++;
        end
        check("abort_start_same_cycle", 32'(bad), 32'd0);

        // Start while busy is ignored, including its config
        @(negedge clk);
        mode = 2'b01; burst_len = 11'd5; rate_div = 8'd0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        n = 0; ones = 0; done_cyc = -1;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (sr_clken) begin n++; if (sr_din) ones++; end
            if (done && done_cyc < 0) done_cyc = k;
            if (k == 2) begin mode = 2'b00; burst_len = 11'd100; rate_div = 8'd3; start = 1'b1; end
            if (k == 3) start = 1'b0;
        end
        check("restart_ignored_strobes", 32'(n), 32'd5);
        check("restart_ignored_ones", 32'(ones), 32'd5);
        check("restart_ignored_done", 32'(done_cyc), 32'd6);

        // Asynchronous reset mid-burst
        @(negedge clk);
        mode = 2'b01; burst_len = 11'd50; rate_div = 8'd0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(negedge clk);
        check("pre_rst_clken", 32'(sr_clken), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_clken", 32'(sr_clken), 32'd0);
        check("async_rst_din", 32'(sr_din), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_done", 32'(done), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        bad = 0;
        repeat (6) begin
            @(negedge clk);
            if (done || sr_clken || busy) bad++;
        end
        check("post_rst_idle", 32'(bad), 32'd0);

`ifdef SR_PATGEN_ERRINJ_EN
        // One injected error flips exactly one bit of an all-ones burst
        @(negedge clk);
        mode = 2'b01; burst_len = 11'd6; rate_div = 8'd0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        n = 0; ones = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (sr_clken) begin n++; if (sr_din) ones++; end
            err_inject = (k == 1);
        end
        err_inject = 1'b0;
        check("errinj_strobes", 32'(n), 32'd6);
        check("errinj_ones", 32'(ones), 32'd5);
        check("errinj_cnt", 32'(err_cnt), 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
